tod_counter: RTL and testbench

- Parametrised BCD time-of-day counter (HH:MM:SS); successor to the per-digit counter chain in the MSF clock.
- Adds an inc prescaler, a runtime 12/24 h display mode with PM flag, load validation with error pulse, and minute/day rollover strobes.
- Sits between the MSF decoder (load path) and the display driver (digit outputs).
- Internal state is always 24 h BCD; 12 h conversion is output-side only.

---
 rtl/tod_counter.sv | 184 ++++++++++++++++++
 tb/tb_tod_counter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/tod_counter.sv
// BCD time-of-day counter (HH:MM:SS, 24 h internal) with inc prescaler, 12/24 h display,
// validated load and minute/day strobes. Optional leap second support via LEAP_SECOND_EN.
module tod_counter #(
  parameter int SEC_DIV    = 1,
  parameter int RESET_HOUR = 0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       inc_i,
  input  logic       mode_12h_i,
`ifdef LEAP_SECOND_EN
  input  logic       leap_i,
`endif
  input  logic       load_i,
  input  logic [1:0] load_hour_h_i,
  input  logic [3:0] load_hour_l_i,
  input  logic [2:0] load_min_h_i,
  input  logic [3:0] load_min_l_i,
  input  logic [2:0] load_sec_h_i,
  input  logic [3:0] load_sec_l_i,
  output logic [1:0] digit_hour_h_o,
  output logic [3:0] digit_hour_l_o,
  output logic [2:0] digit_min_h_o,
  output logic [3:0] digit_min_l_o,
  output logic [2:0] digit_sec_h_o,
  output logic [3:0] digit_sec_l_o,
  output logic       pm_o,
  output logic       min_o,
  output logic       ovf_o,
  output logic       load_err_o
);
  localparam int             PW       = (SEC_DIV > 1) ? $clog2(SEC_DIV) : 1;
  localparam logic [PW-1:0]  PRE_LAST = PW'(SEC_DIV - 1);
  localparam logic [1:0]     RST_HH   = 2'(RESET_HOUR / 10);
  localparam logic [3:0]     RST_HL   = 4'(RESET_HOUR % 10);

  typedef struct packed {
    logic [1:0] hour_h;
    logic [3:0] hour_l;
    logic [2:0] min_h;
    logic [3:0] min_l;
    logic [2:0] sec_h;
    logic [3:0] sec_l;
  } tod_t;

  tod_t          tod_q, tod_adv, tod_ld;
  logic [PW-1:0] pre_q;
  logic          min_q, ovf_q, err_q;
  logic          tick, sec_top, min_top, hour_top, leap_go;
  logic          min_wrap, day_wrap;
  logic          hr_ok, min_ok, sec_ok, ld_ok;

  assign tod_ld = {load_hour_h_i, load_hour_l_i, load_min_h_i, load_min_l_i,
                   load_sec_h_i, load_sec_l_i};

  // Load validation
  assign hr_ok  = (tod_ld.hour_h < 2'd2 && tod_ld.hour_l <= 4'd9) ||
                  (tod_ld.hour_h == 2'd2 && tod_ld.hour_l <= 4'd3);
  assign min_ok = (tod_ld.min_h <= 3'd5) && (tod_ld.min_l <= 4'd9);
`ifdef LEAP_SECOND_EN
  // SS=60 is only a legal load as the last second of the day
  assign sec_ok = ((tod_ld.sec_h <= 3'd5) && (tod_ld.sec_l <= 4'd9)) ||
                  (tod_ld.sec_h == 3'd6 && tod_ld.sec_l == 4'd0 &&
                   tod_ld.hour_h == 2'd2 && tod_ld.hour_l == 4'd3 &&
                   tod_ld.min_h == 3'd5 && tod_ld.min_l == 4'd9);
`else
  assign sec_ok = (tod_ld.sec_h <= 3'd5) && (tod_ld.sec_l <= 4'd9);
`endif
  assign ld_ok  = hr_ok && min_ok && sec_ok;

  assign tick     = inc_i && (pre_q == PRE_LAST);
  assign sec_top  = (tod_q.sec_h == 3'd5 && tod_q.sec_l == 4'd9) || (tod_q.sec_h == 3'd6);
  assign min_top  = (tod_q.min_h == 3'd5) && (tod_q.min_l == 4'd9);
  assign hour_top = (tod_q.hour_h == 2'd2) && (tod_q.hour_l == 4'd3);
`ifdef LEAP_SECOND_EN
  assign leap_go  = leap_i && hour_top && min_top &&
                    (tod_q.sec_h == 3'd5) && (tod_q.sec_l == 4'd9);
`else
  assign leap_go  = 1'b0;
`endif

  // One-second advance with full carry chain resolved in a single edge
  always_comb begin
    tod_adv  = tod_q;
    min_wrap = 1'b0;
    day_wrap = 1'b0;
    if (leap_go) begin
      tod_adv.sec_h = 3'd6;
      tod_adv.sec_l = 4'd0;
    end else if (sec_top) begin
      tod_adv.sec_h = 3'd0;
      tod_adv.sec_l = 4'd0;
      min_wrap      = 1'b1;
      if (min_top) begin
        tod_adv.min_h = 3'd0;
        tod_adv.min_l = 4'd0;
        if (hour_top) begin
          tod_adv.hour_h = 2'd0;
          tod_adv.hour_l = 4'd0;
          day_wrap       = 1'b1;
        end else if (tod_q.hour_l == 4'd9) begin
          tod_adv.hour_l = 4'd0;
          tod_adv.hour_h = tod_q.hour_h + 2'd1;
        end else begin
          tod_adv.hour_l = tod_q.hour_l + 4'd1;
        end
      end else if (tod_q.min_l == 4'd9) begin
        tod_adv.min_l = 4'd0;
        tod_adv.min_h = tod_q.min_h + 3'd1;
      end else begin
        tod_adv.min_l = tod_q.min_l + 4'd1;
      end
    end else if (tod_q.sec_l == 4'd9) begin
      tod_adv.sec_l = 4'd0;
      tod_adv.sec_h = tod_q.sec_h + 3'd1;
    end else begin
      tod_adv.sec_l = tod_q.sec_l + 4'd1;
    end
  end

  // Load has priority over inc; a rejected load still swallows that edge's inc
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tod_q <= '{hour_h: RST_HH, hour_l: RST_HL, default: '0};
      pre_q <= '0;
      min_q <= 1'b0;
      ovf_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      min_q <= 1'b0;
      ovf_q <= 1'b0;
      err_q <= 1'b0;
      if (load_i) begin
        if (ld_ok) begin
          tod_q <= tod_ld;
          pre_q <= '0;
        end else begin
          err_q <= 1'b1;
        end
      end else if (inc_i) begin
        if (tick) begin
          pre_q <= '0;
          tod_q <= tod_adv;
          min_q <= min_wrap;
          ovf_q <= day_wrap;
        end else begin
          pre_q <= pre_q + 1'b1;
        end
      end
    end
  end

  logic [4:0] hour_bin, disp_bin, units;

  always_comb begin
    hour_bin = 5'(tod_q.hour_h) * 5'd10 + 5'(tod_q.hour_l);
    disp_bin = hour_bin;
    if (mode_12h_i) begin
      if (hour_bin == 5'd0)       disp_bin = 5'd12;
      else if (hour_bin > 5'd12)  disp_bin = hour_bin - 5'd12;
    end
    if (disp_bin >= 5'd20) begin
      digit_hour_h_o = 2'd2;
      units          = disp_bin - 5'd20;
    end else if (disp_bin >= 5'd10) begin
      digit_hour_h_o = 2'd1;
      units          = disp_bin - 5'd10;
    end else begin
      digit_hour_h_o = 2'd0;
      units          = disp_bin;
    end
  end

  assign digit_hour_l_o = units[3:0];
  assign digit_min_h_o  = tod_q.min_h;
  assign digit_min_l_o  = tod_q.min_l;
  assign digit_sec_h_o  = tod_q.sec_h;
  assign digit_sec_l_o  = tod_q.sec_l;
  assign pm_o           = (hour_bin >= 5'd12);
  assign min_o          = min_q;
  assign ovf_o          = ovf_q;
  assign load_err_o     = err_q;

endmodule

// File: tb/tb_tod_counter.sv
// Scoreboard bench for tod_counter (SEC_DIV=4, RESET_HOUR=7); leap cases follow LEAP_SECOND_EN.
module tb_tod_counter;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       inc = 1'b0, load = 1'b0, m12 = 1'b0, leap = 1'b0;
  logic [1:0] ld_hh = '0;
  logic [3:0] ld_hl = '0;
  logic [2:0] ld_mh = '0;
  logic [3:0] ld_ml = '0;
  logic [2:0] ld_sh = '0;
  logic [3:0] ld_sl = '0;
  logic [1:0] d_hh;
  logic [3:0] d_hl;
  logic [2:0] d_mh;
  logic [3:0] d_ml;
  logic [2:0] d_sh;
  logic [3:0] d_sl;
  logic       pm, mn, ovf, err;

  int checks = 0;
  int failures = 0;
  logic [23:0] exp_q[$];
  logic [23:0] obs_q[$];

  tod_counter #(.SEC_DIV(4), .RESET_HOUR(7)) dut (
    .clk_i(clk), .rst_i(rst), .inc_i(inc), .mode_12h_i(m12),
`ifdef LEAP_SECOND_EN
    .leap_i(leap),
`endif
    .load_i(load),
    .load_hour_h_i(ld_hh), .load_hour_l_i(ld_hl),
    .load_min_h_i(ld_mh), .load_min_l_i(ld_ml),
    .load_sec_h_i(ld_sh), .load_sec_l_i(ld_sl),
    .digit_hour_h_o(d_hh), .digit_hour_l_o(d_hl),
    .digit_min_h_o(d_mh), .digit_min_l_o(d_ml),
    .digit_sec_h_o(d_sh), .digit_sec_l_o(d_sl),
    .pm_o(pm), .min_o(mn), .ovf_o(ovf), .load_err_o(err)
  );

  always #5 clk = ~clk;

  // Expected word: displayed HH:MM:SS as decimal, then pm, min, ovf, err
  function automatic logic [23:0] pk(input int hh, input int mm, input int ss,
                                     input logic p, input logic m, input logic o, input logic e);
    return {2'(hh / 10), 4'(hh % 10), 3'(mm / 10), 4'(mm % 10),
            3'(ss / 10), 4'(ss % 10), p, m, o, e};
  endfunction

  function automatic logic [23:0] obs();
    return {d_hh, d_hl, d_mh, d_ml, d_sh, d_sl, pm, mn, ovf, err};
  endfunction

  // Called at a negedge: apply inputs, push expectation, capture DUT state one cycle later
  task automatic drive(input logic i, input logic l, input int hh, input int mm, input int ss,
                       input logic md, input logic lp, input logic [23:0] e);
    inc = i; load = l; m12 = md; leap = lp;
    ld_hh = 2'(hh / 10); ld_hl = 4'(hh % 10);
    ld_mh = 3'(mm / 10); ld_ml = 4'(mm % 10);
    ld_sh = 3'(ss / 10); ld_sl = 4'(ss % 10);
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    obs_q.push_back(obs());
    inc = 1'b0; load = 1'b0;
  endtask

  // Load, three incs that stay inside the prescaler, then the advancing inc
  task automatic run4(input int hh, input int mm, input int ss, input logic lp,
                      input logic [23:0] e_ld, input logic [23:0] e_adv);
    drive(0, 1, hh, mm, ss, 0, 0, e_ld);
    for (int k = 0; k < 3; k++) drive(1, 0, 0, 0, 0, 0, lp, e_ld);
    drive(1, 0, 0, 0, 0, 0, lp, e_adv);
  endtask

  task automatic test_reset();
    logic [23:0] e, o;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    exp_q.push_back(pk(7, 0, 0, 0, 0, 0, 0));
    obs_q.push_back(obs());
    rst = 1'b0;
    for (int k = 0; k < 5; k++)
      drive(1, 0, 0, 0, 0, 0, 0, (k >= 3) ? pk(7, 0, 1, 0, 0, 0, 0) : pk(7, 0, 0, 0, 0, 0, 0));
    rst = 1'b1;
    #1;
    exp_q.push_back(pk(7, 0, 0, 0, 0, 0, 0));
    obs_q.push_back(obs());
    inc = 1'b1;
    @(posedge clk);
    @(negedge clk);
    exp_q.push_back(pk(7, 0, 0, 0, 0, 0, 0));
    obs_q.push_back(obs());
    inc = 1'b0;
    rst = 1'b0;
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL reset[%0d] got=%h expected=%h", k, o, e);
      end
    end
  endtask

  task automatic test_carry();
    logic [23:0] e, o;
    drive(0, 1, 23, 59, 58, 0, 0, pk(23, 59, 58, 1, 0, 0, 0));
    for (int k = 0; k < 8; k++)
      drive(1, 0, 0, 0, 0, 0, 0, (k == 7) ? pk(0, 0, 0, 0, 1, 1, 0) :
                                 (k >= 3) ? pk(23, 59, 59, 1, 0, 0, 0) :
                                            pk(23, 59, 58, 1, 0, 0, 0));
    drive(0, 0, 0, 0, 0, 0, 0, pk(0, 0, 0, 0, 0, 0, 0));
    run4(0, 0, 59, 0, pk(0, 0, 59, 0, 0, 0, 0), pk(0, 1, 0, 0, 1, 0, 0));
    run4(9, 59, 59, 0, pk(9, 59, 59, 0, 0, 0, 0), pk(10, 0, 0, 0, 1, 0, 0));
    run4(12, 34, 9, 0, pk(12, 34, 9, 1, 0, 0, 0), pk(12, 34, 10, 1, 0, 0, 0));
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL carry[%0d] got=%h expected=%h", k, o, e);
      end
    end
  endtask

  task automatic test_load();
    logic [23:0] e, o;
    drive(0, 1, 0, 0, 0, 0, 0, pk(0, 0, 0, 0, 0, 0, 0));
    drive(1, 0, 0, 0, 0, 0, 0, pk(0, 0, 0, 0, 0, 0, 0));
    drive(1, 0, 0, 0, 0, 0, 0, pk(0, 0, 0, 0, 0, 0, 0));
    // rejected load with inc: prescaler stays at 2, so two more incs reach the second
    drive(1, 1, 25, 0, 0, 0, 0, pk(0, 0, 0, 0, 0, 0, 1));
    drive(0, 0, 0, 0, 0, 0, 0, pk(0, 0, 0, 0, 0, 0, 0));
    drive(1, 0, 0, 0, 0, 0, 0, pk(0, 0, 0, 0, 0, 0, 0));
    drive(1, 0, 0, 0, 0, 0, 0, pk(0, 0, 1, 0, 0, 0, 0));
    drive(1, 0, 0, 0, 0, 0, 0, pk(0, 0, 1, 0, 0, 0, 0));
    drive(1, 0, 0, 0, 0, 0, 0, pk(0, 0, 1, 0, 0, 0, 0));
    // valid load with inc clears the prescaler: four more incs needed
    drive(1, 1, 12, 34, 56, 0, 0, pk(12, 34, 56, 1, 0, 0, 0));
    for (int k = 0; k < 3; k++) drive(1, 0, 0, 0, 0, 0, 0, pk(12, 34, 56, 1, 0, 0, 0));
    drive(1, 0, 0, 0, 0, 0, 0, pk(12, 34, 57, 1, 0, 0, 0));
    drive(0, 1, 12, 60, 0, 0, 0, pk(12, 34, 57, 1, 0, 0, 1));
    drive(0, 1, 24, 0, 0, 0, 0, pk(12, 34, 57, 1, 0, 0, 1));
    drive(0, 1, 23, 59, 59, 0, 0, pk(23, 59, 59, 1, 0, 0, 0));
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL load[%0d] got=%h expected=%h", k, o, e);
      end
    end
  endtask

  task automatic test_mode12();
    logic [23:0] e, o;
    drive(0, 1, 0, 15, 0, 1, 0, pk(12, 15, 0, 0, 0, 0, 0));
    drive(0, 1, 12, 0, 0, 1, 0, pk(12, 0, 0, 1, 0, 0, 0));
    drive(0, 1, 13, 5, 0, 1, 0, pk(1, 5, 0, 1, 0, 0, 0));
    drive(0, 1, 11, 0, 0, 1, 0, pk(11, 0, 0, 0, 0, 0, 0));
    drive(0, 1, 23, 0, 0, 1, 0, pk(11, 0, 0, 1, 0, 0, 0));
    m12 = 1'b0;
    #1;
    exp_q.push_back(pk(23, 0, 0, 1, 0, 0, 0));
    obs_q.push_back(obs());
    m12 = 1'b1;
    #1;
    exp_q.push_back(pk(11, 0, 0, 1, 0, 0, 0));
    obs_q.push_back(obs());
    m12 = 1'b0;
    @(negedge clk);
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL mode12[%0d] got=%h expected=%h", k, o, e);
      end
    end
  endtask

`ifdef LEAP_SECOND_EN
  task automatic test_leap();
    logic [23:0] e, o;
    run4(23, 59, 59, 1, pk(23, 59, 59, 1, 0, 0, 0), pk(23, 59, 60, 1, 0, 0, 0));
    for (int k = 0; k < 4; k++)
      drive(1, 0, 0, 0, 0, 0, 0, (k == 3) ? pk(0, 0, 0, 0, 1, 1, 0) : pk(23, 59, 60, 1, 0, 0, 0));
    drive(0, 1, 10, 0, 60, 0, 0, pk(0, 0, 0, 0, 0, 0, 1));
    run4(10, 0, 59, 1, pk(10, 0, 59, 0, 0, 0, 0), pk(10, 1, 0, 0, 1, 0, 0));
    run4(23, 59, 60, 0, pk(23, 59, 60, 1, 0, 0, 0), pk(0, 0, 0, 0, 1, 1, 0));
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL leap[%0d] got=%h expected=%h", k, o, e);
      end
    end
  endtask
`else
  task automatic test_no_leap();
    logic [23:0] e, o;
    drive(0, 1, 12, 0, 0, 0, 0, pk(12, 0, 0, 1, 0, 0, 0));
    drive(0, 1, 23, 59, 60, 0, 0, pk(12, 0, 0, 1, 0, 0, 1));
    drive(0, 0, 0, 0, 0, 0, 0, pk(12, 0, 0, 1, 0, 0, 0));
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL no_leap[%0d] got=%h expected=%h", k, o, e);
      end
    end
  endtask
`endif

  initial begin
    #1;
    test_reset();
    test_carry();
    test_load();
    test_mode12();
`ifdef LEAP_SECOND_EN
    test_leap();
`else
    test_no_leap();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
